// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN window sequencer.
package snn_pkg;

  localparam int unsigned SAMPLE_W = 6;
  localparam int unsigned CLASS_W  = 2;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ARM    = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } seq_state_t;

  // Result payload presented on the result port
  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic               no_spike;
    logic               timeout;
  } seq_result_t;

endpackage

// File: rtl/snn_window_ram.sv
// Window sample buffer: one write port, one registered synchronous read port.
module snn_window_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Sample storage, written on accepted stream beats
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/snn_window_sequencer.sv
// Window sequencer feeding the SNN ECG classifier core: buffers one window,
// arms and runs the core, and returns the classification on a valid/ready port.
// Optional build macro SNN_SEQ_CYCLES_EN adds res_cycles (RUN cycle count).
module snn_window_sequencer #(
  parameter int unsigned WIN_LEN    = 256,
  parameter int unsigned SAMPLE_W   = snn_pkg::SAMPLE_W,
  parameter int unsigned ARM_CYCLES = 3,
  parameter int unsigned MAX_CYCLES = 65535,
  parameter int unsigned IDX_W      = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [SAMPLE_W-1:0]          s_data,
  input  logic [$clog2(WIN_LEN)-1:0]   win_addr,
  output logic [SAMPLE_W-1:0]          win_data,
  output logic                         core_resetn,
  input  logic                         core_done,
  input  logic [snn_pkg::CLASS_W-1:0]  core_class,
  input  logic                         core_no_spike,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [snn_pkg::CLASS_W-1:0]  res_class,
  output logic                         res_no_spike,
  output logic                         res_timeout,
  output logic [IDX_W-1:0]             res_index,
`ifdef SNN_SEQ_CYCLES_EN
  output logic [IDX_W-1:0]             res_cycles,
`endif
  output logic                         busy
);

  import snn_pkg::*;

  localparam int unsigned ADDR_W = $clog2(WIN_LEN);
  localparam int unsigned ARM_W  = $clog2(ARM_CYCLES + 1);
  localparam int unsigned RUN_W  = $clog2(MAX_CYCLES + 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              res_valid_d;
  seq_result_t       res_q, res_d;
  logic [IDX_W-1:0]  res_index_d;
  logic              win_we;

`ifdef SNN_SEQ_CYCLES_EN
  localparam int unsigned SAT_W = (RUN_W + 1 > IDX_W) ? RUN_W + 1 : IDX_W;
  logic [SAT_W-1:0] run_len;
  logic [IDX_W-1:0] run_len_sat;
  logic [IDX_W-1:0] cycles_d;

  // RUN cycles including the current one, saturated to the port width
  always_comb begin
    run_len     = SAT_W'(run_cnt_q) + 1'b1;
    run_len_sat = (run_len > SAT_W'({IDX_W{1'b1}})) ? {IDX_W{1'b1}} : IDX_W'(run_len);
  end
`endif

  // Next-state, counters and result capture
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    arm_cnt_d   = arm_cnt_q;
    run_cnt_d   = run_cnt_q;
    res_valid_d = res_valid;
    res_d       = res_q;
    res_index_d = res_index;
    win_we      = 1'b0;
`ifdef SNN_SEQ_CYCLES_EN
    cycles_d    = res_cycles;
`endif
    case (state_q)
      FILL: begin
        if (s_valid && s_ready) begin
          win_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == ADDR_W'(WIN_LEN - 1)) begin
            state_d   = ARM;
            arm_cnt_d = '0;
          end
        end
      end
      ARM: begin
        arm_cnt_d = arm_cnt_q + 1'b1;
        if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (core_done) begin
          res_d       = '{cls: core_class, no_spike: core_no_spike, timeout: 1'b0};
          res_valid_d = 1'b1;
          state_d     = RESULT;
`ifdef SNN_SEQ_CYCLES_EN
          cycles_d    = run_len_sat;
`endif
        end else if (run_cnt_q == RUN_W'(MAX_CYCLES - 1)) begin
          res_d       = '{cls: '0, no_spike: 1'b1, timeout: 1'b1};
          res_valid_d = 1'b1;
          state_d     = RESULT;
`ifdef SNN_SEQ_CYCLES_EN
          cycles_d    = run_len_sat;
`endif
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_index_d = res_index + 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and registered outputs; core leaves reset one cycle after RUN entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      arm_cnt_q   <= '0;
      run_cnt_q   <= '0;
      res_valid   <= 1'b0;
      res_q       <= '0;
      res_index   <= '0;
      s_ready     <= 1'b1;
      busy        <= 1'b0;
      core_resetn <= 1'b0;
`ifdef SNN_SEQ_CYCLES_EN
      res_cycles  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      arm_cnt_q   <= arm_cnt_d;
      run_cnt_q   <= run_cnt_d;
      res_valid   <= res_valid_d;
      res_q       <= res_d;
      res_index   <= res_index_d;
      s_ready     <= (state_d == FILL);
      busy        <= (state_d != FILL);
      core_resetn <= (state_q == RUN) && (state_d == RUN);
`ifdef SNN_SEQ_CYCLES_EN
      res_cycles  <= cycles_d;
`endif
    end
  end

  assign res_class    = res_q.cls;
  assign res_no_spike = res_q.no_spike;
  assign res_timeout  = res_q.timeout;

  snn_window_ram #(
    .DEPTH (WIN_LEN),
    .WIDTH (SAMPLE_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(resetn),
    .we   (win_we),
    .waddr(wr_ptr_q),
    .wdata(s_data),
    .raddr(win_addr),
    .rdata(win_data)
  );

endmodule

// File: tb/tb_snn_window_sequencer.sv
// Scoreboard bench for snn_window_sequencer with a behavioural core model.
module tb_snn_window_sequencer;

  localparam int unsigned WIN_LEN    = 256;
  localparam int unsigned SW         = 6;
  localparam int unsigned ARM_CYCLES = 3;
  localparam int unsigned MAX_CYCLES = 40;
  localparam int unsigned IDX_W      = 16;

  logic             clk;
  logic             resetn;
  logic             s_valid;
  logic             s_ready;
  logic [SW-1:0]    s_data;
  logic [7:0]       win_addr;
  logic [SW-1:0]    win_data;
  logic             core_resetn;
  logic             core_done;
  logic [1:0]       core_class;
  logic             core_no_spike;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_class;
  logic             res_no_spike;
  logic             res_timeout;
  logic [IDX_W-1:0] res_index;
`ifdef SNN_SEQ_CYCLES_EN
  logic [IDX_W-1:0] res_cycles;
`endif
  logic             busy;

  snn_window_sequencer #(
    .WIN_LEN   (WIN_LEN),
    .SAMPLE_W  (SW),
    .ARM_CYCLES(ARM_CYCLES),
    .MAX_CYCLES(MAX_CYCLES),
    .IDX_W     (IDX_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .win_addr     (win_addr),
    .win_data     (win_data),
    .core_resetn  (core_resetn),
    .core_done    (core_done),
    .core_class   (core_class),
    .core_no_spike(core_no_spike),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_class    (res_class),
    .res_no_spike (res_no_spike),
    .res_timeout  (res_timeout),
    .res_index    (res_index),
`ifdef SNN_SEQ_CYCLES_EN
    .res_cycles   (res_cycles),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int ns;
    int to;
    int idx;
    int cyc;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   exp_win[WIN_LEN];
  int   win_count = 0;
  bit   allow_ready = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected result from the core's response: done in RUN cycle n (n<=MAX) or never
  function automatic exp_t model(input int n, input int cls, input int ns);
    exp_t e;
    e.idx = win_count;
    if (n >= 1 && n <= int'(MAX_CYCLES)) begin
      e.cls = cls; e.ns = ns; e.to = 0; e.cyc = n;
    end else begin
      e.cls = 0; e.ns = 1; e.to = 1; e.cyc = int'(MAX_CYCLES);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random consumer back-pressure, only enabled while draining a result
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = allow_ready && ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold stability
  initial begin : monitor
    bit   hold;
    int   p_cls, p_ns, p_to, p_idx;
    exp_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", int'(res_valid), 1);
          chk("hold_class", int'(res_class), p_cls);
          chk("hold_nospike", int'(res_no_spike), p_ns);
          chk("hold_timeout", int'(res_timeout), p_to);
          chk("hold_index", int'(res_index), p_idx);
        end
        if (res_valid && res_ready) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("res_class", int'(res_class), e.cls);
            chk("res_no_spike", int'(res_no_spike), e.ns);
            chk("res_timeout", int'(res_timeout), e.to);
            chk("res_index", int'(res_index), e.idx);
`ifdef SNN_SEQ_CYCLES_EN
            chk("res_cycles", int'(res_cycles), e.cyc);
`endif
          end
        end else if (res_valid) begin
          hold  = 1'b1;
          p_cls = int'(res_class);
          p_ns  = int'(res_no_spike);
          p_to  = int'(res_timeout);
          p_idx = int'(res_index);
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  // Stream one window; abort_at>=0 stops after that many accepts
  task automatic fill(input bit gaps, input int abort_at);
    int d;
    for (int i = 0; i < int'(WIN_LEN); i++) begin
      if (i == abort_at) begin
        s_valid = 1'b0;
        return;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          s_valid = 1'b0;
          tick();
        end
      end
      d = gaps ? int'($urandom_range(0, 63)) : (i % 64);
      if (i == int'(WIN_LEN) - 1) chk("s_ready_last", int'(s_ready), 1);
      s_valid    = 1'b1;
      s_data     = SW'(d);
      exp_win[i] = d;
      tick();
    end
    s_valid = 1'b0;
    chk("s_ready_drop", int'(s_ready), 0);
    chk("busy_after_fill", int'(busy), 1);
  endtask

  // Core must stay in reset until T+1+ARM_CYCLES; optional spurious done during ARM
  task automatic arm_check(input bit distract);
    if (distract) begin
      core_done     = 1'b1;
      core_class    = 2'd3;
      core_no_spike = 1'b1;
    end
    for (int k = 0; k <= int'(ARM_CYCLES) + 1; k++) begin
      if (k == int'(ARM_CYCLES)) core_done = 1'b0;
      chk("core_resetn_arm", int'(core_resetn), (k == int'(ARM_CYCLES) + 1) ? 1 : 0);
      if (k < int'(ARM_CYCLES) + 1) tick();
    end
  endtask

  // Behavioural core: end_process in RUN cycle n (n outside 1..MAX means never)
  task automatic respond(input int n, input int cls, input int ns);
    exp_q.push_back(model(n, cls, ns));
    chk("busy_run", int'(busy), 1);
    if (n >= 2 && n <= int'(MAX_CYCLES)) begin
      repeat (n - 2) tick();
      core_done     = 1'b1;
      core_class    = 2'(cls);
      core_no_spike = ns[0];
      tick();
      core_done     = 1'b0;
      core_class    = 2'($urandom_range(0, 3));
      core_no_spike = 1'($urandom_range(0, 1));
      chk("done_latency", int'(res_valid), 1);
    end else begin
      int k;
      k = 0;
      while (!res_valid && k < int'(MAX_CYCLES) + 5) begin
        tick();
        k++;
      end
      chk("timeout_latency", k, int'(MAX_CYCLES) - 1);
    end
  endtask

  // Verify buffer while result is held, then release and await handshake
  task automatic drain();
    int k;
    for (int a = 0; a < int'(WIN_LEN); a++) begin
      win_addr = 8'(a);
      tick();
      if (win_data != SW'(exp_win[a])) chk("buf_data", int'(win_data), exp_win[a]);
      else total++;
    end
    chk("core_resetn_result", int'(core_resetn), 0);
    allow_ready = 1'b1;
    k = 0;
    while (res_valid && k < 300) begin
      tick();
      k++;
    end
    allow_ready = 1'b0;
    chk("res_released", int'(res_valid), 0);
    win_count++;
    chk("s_ready_refill", int'(s_ready), 1);
    chk("busy_refill", int'(busy), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_core_resetn", int'(core_resetn), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_class", int'(res_class), 0);
    chk("rst_res_no_spike", int'(res_no_spike), 0);
    chk("rst_res_timeout", int'(res_timeout), 0);
    chk("rst_res_index", int'(res_index), 0);
    chk("rst_win_data", int'(win_data), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef SNN_SEQ_CYCLES_EN
    chk("rst_res_cycles", int'(res_cycles), 0);
`endif
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values();
    s_valid   = 1'b0;
    core_done = 1'b0;
    exp_q.delete();
    win_count = 0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    resetn        = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    win_addr      = '0;
    core_done     = 1'b0;
    core_class    = '0;
    core_no_spike = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Window 0: back-to-back ramp, class 2 result held under back-pressure
    fill(1'b0, -1);
    arm_check(1'b0);
    respond(10, 2, 0);
    drain();

    // Windows 1,2: gapped streams, spurious done in ARM, done at the watchdog limit
    fill(1'b1, -1);
    arm_check(1'b1);
    respond(int'($urandom_range(2, MAX_CYCLES - 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    drain();
    fill(1'b1, -1);
    arm_check(1'b0);
    respond(int'(MAX_CYCLES), 1, 0);
    drain();

    // Reset mid-fill, then a timeout window starting from index 0
    fill(1'b1, 100);
    async_reset();
    fill(1'b1, -1);
    arm_check(1'b0);
    respond(0, 0, 0);
    drain();

    // Reset mid-run
    fill(1'b0, -1);
    arm_check(1'b0);
    repeat (7) tick();
    async_reset();

    // Done after 37 RUN cycles
    fill(1'b1, -1);
    arm_check(1'b0);
    respond(37, 1, 1);
    drain();

    // A few random windows, some of which time out
    for (int w = 0; w < 3; w++) begin
      n = int'($urandom_range(2, MAX_CYCLES + 5));
      fill(1'b1, -1);
      arm_check(1'($urandom_range(0, 1)));
      respond(n, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      drain();
    end

    chk("final_index", int'(res_index), win_count);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
